// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Desc     : Stall/bubble/kill/forwarding control for a 4-stage D-A-M-W pipe,
//            with saturating stall and flush performance counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REGNOBITS = 6,
    parameter bit FWD_EN    = 1'b1,
    parameter int CNTBITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_D,
    input  logic [REGNOBITS-1:0] rs_D,
    input  logic [REGNOBITS-1:0] rt_D,
    input  logic                 uses_rs_D,
    input  logic                 uses_rt_D,
    input  logic                 wrreg_D,
    input  logic [REGNOBITS-1:0] wregno_D,
    input  logic                 isload_D,
    input  logic                 mispred_A,
    input  logic                 cnt_clr,
    output logic                 stall_F,
    output logic                 stall_D,
    output logic                 bubble_A,
    output logic                 kill_D,
    output logic [1:0]           fwd1_D,
    output logic [1:0]           fwd2_D,
    output logic [CNTBITS-1:0]   stall_cnt,
    output logic [CNTBITS-1:0]   flush_cnt
);

    localparam logic [CNTBITS-1:0] c_cnt_one = {{(CNTBITS-1){1'b0}}, 1'b1};
    localparam logic [CNTBITS-1:0] c_cnt_max = {CNTBITS{1'b1}};

    // Only slot A needs the load flag; M and W results are always forwardable.
    logic                 r_a_wr, r_a_ld, r_m_wr, r_w_wr;
    logic [REGNOBITS-1:0] r_a_reg, r_m_reg, r_w_reg;
    logic [CNTBITS-1:0]   r_stall_cnt, r_flush_cnt;

    logic w_need_rs, w_need_rt;
    logic w_rs_a, w_rs_m, w_rs_w;
    logic w_rt_a, w_rt_m, w_rt_w;
    logic w_hazard;
    logic [1:0] w_fwd1, w_fwd2;

    assign w_need_rs = valid_D & uses_rs_D;
    assign w_need_rt = valid_D & uses_rt_D;

    assign w_rs_a = w_need_rs & r_a_wr & (r_a_reg == rs_D);
    assign w_rs_m = w_need_rs & r_m_wr & (r_m_reg == rs_D);
    assign w_rs_w = w_need_rs & r_w_wr & (r_w_reg == rs_D);
    assign w_rt_a = w_need_rt & r_a_wr & (r_a_reg == rt_D);
    assign w_rt_m = w_need_rt & r_m_wr & (r_m_reg == rt_D);
    assign w_rt_w = w_need_rt & r_w_wr & (r_w_reg == rt_D);

    generate
        if (FWD_EN) begin : g_fwd
            always_comb begin
                w_hazard = (w_rs_a | w_rt_a) & r_a_ld;
                w_fwd1   = 2'd0;
                w_fwd2   = 2'd0;
                if (w_rs_a && !r_a_ld) w_fwd1 = 2'd1;
                else if (w_rs_m)       w_fwd1 = 2'd2;
                else if (w_rs_w)       w_fwd1 = 2'd3;
                if (w_rt_a && !r_a_ld) w_fwd2 = 2'd1;
                else if (w_rt_m)       w_fwd2 = 2'd2;
                else if (w_rt_w)       w_fwd2 = 2'd3;
            end
        end else begin : g_stall
            logic w_unused_ld;
            assign w_unused_ld = r_a_ld;
            always_comb begin
                w_hazard = w_rs_a | w_rs_m | w_rs_w | w_rt_a | w_rt_m | w_rt_w;
                w_fwd1   = 2'd0;
                w_fwd2   = 2'd0;
            end
        end
    endgenerate

    // A mispredict squashes D, so its hazard no longer matters.
    assign kill_D   = mispred_A & ~reset;
    assign stall_D  = w_hazard & ~mispred_A & ~reset;
    assign stall_F  = stall_D;
    assign bubble_A = w_hazard | mispred_A | reset;
    assign fwd1_D   = reset ? 2'd0 : w_fwd1;
    assign fwd2_D   = reset ? 2'd0 : w_fwd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_wr  <= 1'b0;
            r_a_reg <= '0;
            r_a_ld  <= 1'b0;
            r_m_wr  <= 1'b0;
            r_m_reg <= '0;
            r_w_wr  <= 1'b0;
            r_w_reg <= '0;
        end else begin
            if (bubble_A) begin
                r_a_wr  <= 1'b0;
                r_a_reg <= '0;
                r_a_ld  <= 1'b0;
            end else begin
                r_a_wr  <= valid_D & wrreg_D;
                r_a_reg <= wregno_D;
                r_a_ld  <= isload_D;
            end
            r_m_wr  <= r_a_wr;
            r_m_reg <= r_a_reg;
            r_w_wr  <= r_m_wr;
            r_w_reg <= r_m_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_D && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (kill_D && (r_flush_cnt != c_cnt_max))  r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
